// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_test_sequencer
// Description : Drives a 2-input gate through its four input vectors, samples
//               the gate output after a programmable settle time and checks it
//               against the golden truth table of the selected function.
//               Reports pass/fail, a mismatch count and a per-vector map.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_sel,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_map
);

  // Last counter value of the settle window; APPLY leaves when it is reached.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_a_q, gate_a_d;
  logic             gate_b_q, gate_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_count_q, err_count_d;
  logic [3:0]       err_map_q, err_map_d;
  logic             mismatch;

  // Golden truth table; codes 6/7 never reach CHECK so their value is unused.
  function automatic logic golden(input logic [2:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a & b);
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      err_map_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_map_q   <= err_map_d;
    end
  end

  // Next-state logic: sweep the four vectors, settle, sample, accumulate.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_map_d   = err_map_q;
    mismatch    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d        = op_sel;
          err_count_d = 3'd0;
          err_map_d   = 4'd0;
          pass_d      = 1'b0;
          idx_d       = 2'd0;
          cnt_d       = '0;
          gate_a_d    = 1'b0;
          gate_b_d    = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_APPLY;
        end
      end

      S_APPLY: begin
        if (op_q > 3'd5) begin
          // Unsupported function: every vector is reported as failing.
          err_map_d   = 4'hF;
          err_count_d = 3'd4;
          pass_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CHECK: begin
        mismatch = (gate_y != golden(op_q, gate_a_q, gate_b_q));
        if (mismatch) begin
          err_map_d[idx_q] = 1'b1;
          err_count_d      = err_count_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          // Pass reflects the count including this final sample.
          pass_d  = (err_count_d == 3'd0);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d    = idx_q + 2'd1;
          gate_a_d = idx_d[1];
          gate_b_d = idx_d[0];
          state_d  = S_APPLY;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_map   = err_map_q;

endmodule
`default_nettype wire
